// File: rtl/multicycle_control_fsm.sv
// Multicycle RV64 control sequencer: per-state datapath enables and selects,
// memory-ready stalls, saturating retired-instruction counter and halt flag.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
  // DECODE   | branch/jump target into ALUOut, dispatch on opcode
  // MEM_ADDR | effective address rs1 + imm
  // MEM_RD   | load read, stalls on mem_ready
  // MEM_WB   | MDR into register file
  // MEM_WR   | store write, stalls on mem_ready
  // EXEC_R   | rs1 op rs2
  // EXEC_I   | rs1 op imm
  // ALU_WB   | ALUOut into register file
  // BRANCH   | compare, PC <= target when equal
  // JAL      | link PC into rd, PC <= target
  // HALT     | illegal opcode, absorbing until reset

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default:            state_d = S_HALT;
        endcase
      end
      // opcode is held stable by the datapath, so it still selects load vs store here
      S_MEM_ADDR: begin
        if (opcode == OP_LOAD)       state_d = S_MEM_RD;
        else if (opcode == OP_STORE) state_d = S_MEM_WR;
        else                         state_d = S_HALT;
      end
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  assign retired_d = (retire && (retired_q != {CNT_W{1'b1}})) ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = (state_q == S_EXEC_I) ? 2'b10 : 2'b00;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_en     = zero;
      end
      // link (PC already +4) and jump target share one edge
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_src     = 1'b1;
        pc_en      = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      pc_en      = 1'b0;
      pc_src     = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven check of the multicycle control FSM, with a second
// 3-bit-counter instance sharing stimulus to exercise retired saturation.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write, halted;
  logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        s_pc_en, s_pc_src, s_iord, s_mem_read, s_mem_write, s_ir_write, s_reg_write, s_halted;
  logic [1:0]  s_mem_to_reg, s_alu_src_a, s_alu_src_b, s_alu_op;
  logic [3:0]  s_state;
  logic [2:0]  s_retired;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .retired(retired), .halted(halted)
  );

  multicycle_control_fsm #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .pc_src(s_pc_src), .iord(s_iord), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .ir_write(s_ir_write), .reg_write(s_reg_write), .mem_to_reg(s_mem_to_reg),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
    .state(s_state), .retired(s_retired), .halted(s_halted)
  );

  // {pc_en,pc_src,iord,mem_read,mem_write,ir_write,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_op,halted}
  logic [15:0] act_ctrl;
  assign act_ctrl = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, halted};

  localparam logic [15:0] C_NONE    = 16'h0000;
  localparam logic [15:0] C_FETCH   = {7'b1001010, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [15:0] C_FWAIT   = {7'b0001000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [15:0] C_DECODE  = {7'b0000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] C_MADDR   = {7'b0000000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] C_MRD     = {7'b0011000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] C_MWB     = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] C_MWR     = {7'b0010100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] C_EXR     = {7'b0000000, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [15:0] C_EXI     = {7'b0000000, 2'b00, 2'b01, 2'b10, 2'b10, 1'b0};
  localparam logic [15:0] C_AWB     = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] C_BR_T    = {7'b1100000, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [15:0] C_BR_N    = {7'b0100000, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [15:0] C_JAL     = {7'b1100001, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] C_HALT    = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctrl;
    int          ret;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(logic [6:0] op, logic z, logic rdy, logic [3:0] st, logic [15:0] ctrl, int ret);
    vec_t r;
    r.op = op; r.z = z; r.rdy = rdy; r.st = st; r.ctrl = ctrl; r.ret = ret;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // R-type
    vq.push_back(v(OP_R,   0, 1, 4'd0,  C_FETCH,  0));
    vq.push_back(v(OP_R,   0, 1, 4'd1,  C_DECODE, 0));
    vq.push_back(v(OP_R,   0, 1, 4'd6,  C_EXR,    0));
    vq.push_back(v(OP_R,   0, 1, 4'd8,  C_AWB,    0));
    // load with three wait cycles
    vq.push_back(v(OP_LD,  0, 1, 4'd0,  C_FETCH,  1));
    vq.push_back(v(OP_LD,  0, 1, 4'd1,  C_DECODE, 1));
    vq.push_back(v(OP_LD,  0, 1, 4'd2,  C_MADDR,  1));
    vq.push_back(v(OP_LD,  0, 0, 4'd3,  C_MRD,    1));
    vq.push_back(v(OP_LD,  0, 0, 4'd3,  C_MRD,    1));
    vq.push_back(v(OP_LD,  0, 0, 4'd3,  C_MRD,    1));
    vq.push_back(v(OP_LD,  0, 1, 4'd3,  C_MRD,    1));
    vq.push_back(v(OP_LD,  0, 1, 4'd4,  C_MWB,    1));
    // store with one wait cycle
    vq.push_back(v(OP_SD,  0, 1, 4'd0,  C_FETCH,  2));
    vq.push_back(v(OP_SD,  0, 1, 4'd1,  C_DECODE, 2));
    vq.push_back(v(OP_SD,  0, 1, 4'd2,  C_MADDR,  2));
    vq.push_back(v(OP_SD,  0, 0, 4'd5,  C_MWR,    2));
    vq.push_back(v(OP_SD,  0, 1, 4'd5,  C_MWR,    2));
    // branch taken, then not taken
    vq.push_back(v(OP_BEQ, 1, 1, 4'd0,  C_FETCH,  3));
    vq.push_back(v(OP_BEQ, 1, 1, 4'd1,  C_DECODE, 3));
    vq.push_back(v(OP_BEQ, 1, 1, 4'd9,  C_BR_T,   3));
    vq.push_back(v(OP_BEQ, 0, 1, 4'd0,  C_FETCH,  4));
    vq.push_back(v(OP_BEQ, 0, 1, 4'd1,  C_DECODE, 4));
    vq.push_back(v(OP_BEQ, 0, 1, 4'd9,  C_BR_N,   4));
    // I-type
    vq.push_back(v(OP_I,   0, 1, 4'd0,  C_FETCH,  5));
    vq.push_back(v(OP_I,   0, 1, 4'd1,  C_DECODE, 5));
    vq.push_back(v(OP_I,   0, 1, 4'd7,  C_EXI,    5));
    vq.push_back(v(OP_I,   0, 1, 4'd8,  C_AWB,    5));
    // JAL twice, second after a fetch stall
    vq.push_back(v(OP_JAL, 0, 1, 4'd0,  C_FETCH,  6));
    vq.push_back(v(OP_JAL, 0, 1, 4'd1,  C_DECODE, 6));
    vq.push_back(v(OP_JAL, 0, 1, 4'd10, C_JAL,    6));
    vq.push_back(v(OP_JAL, 0, 0, 4'd0,  C_FWAIT,  7));
    vq.push_back(v(OP_JAL, 0, 1, 4'd0,  C_FETCH,  7));
    vq.push_back(v(OP_JAL, 0, 1, 4'd1,  C_DECODE, 7));
    vq.push_back(v(OP_JAL, 0, 1, 4'd10, C_JAL,    7));
    // illegal opcode
    vq.push_back(v(OP_BAD, 0, 1, 4'd0,  C_FETCH,  8));
    vq.push_back(v(OP_BAD, 0, 1, 4'd1,  C_DECODE, 8));
    vq.push_back(v(OP_BAD, 0, 1, 4'd11, C_HALT,   8));

    reset = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctrl", 32'(act_ctrl), 32'(C_NONE));
    chk("reset_retired", retired, 32'd0);
    chk("reset_sat_retired", 32'(s_retired), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vq[i]) begin
      opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vq[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(act_ctrl), 32'(vq[i].ctrl));
      chk($sformatf("vec%0d_retired", i), retired, 32'(vq[i].ret));
      chk($sformatf("vec%0d_sat_retired", i), 32'(s_retired), 32'((vq[i].ret > 7) ? 7 : vq[i].ret));
      @(posedge clk); #1;
    end

    // HALT is absorbing and freezes the counter
    for (int c = 0; c < 10; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      opcode = OP_R;
      @(negedge clk);
      chk("halt_state", 32'(state), 32'd11);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_retired", retired, 32'd8);
      @(posedge clk); #1;
    end

    // asynchronous reset between edges
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_ctrl", 32'(act_ctrl), 32'(C_NONE));
    chk("async_retired", retired, 32'd0);

    // reset mid-instruction aborts without retiring
    @(posedge clk); #1;
    opcode = OP_R; mem_ready = 1'b1; zero = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pre_state", 32'(state), 32'd6);
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_ctrl", 32'(act_ctrl), 32'(C_NONE));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("resume_state", 32'(state), 32'd0);
    chk("resume_retired", retired, 32'd0);

    // nine back-to-back R-types: 3-bit counter saturates at 7
    for (int k = 1; k <= 9; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat_r%0d_state", k), 32'(state), 32'd0);
      chk($sformatf("sat_r%0d_retired", k), retired, 32'(k));
      chk($sformatf("sat_r%0d_sat_retired", k), 32'(s_retired), 32'((k > 7) ? 7 : k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Control-sequencing FSM that converts the RV64 single-cycle datapath into a multicycle datapath sharing one ALU and one unified instruction/data memory port. It decodes the opcode held in the instruction register and drives per-state enables and mux selects, stalling on a memory-ready handshake. It also provides a retired-instruction counter and a halt flag for the top-level debug outputs.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
opcode  in  7  instruction[6:0] from instruction register
zero  in  1  ALU ZERO flag, current cycle
mem_ready  in  1  memory completes current read/write this cycle
pc_en  out  1  PC register load enable
pc_src  out  1  0 = ALU result, 1 = ALUOut register
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register and old-PC register load
reg_write  out  1  register file write enable
mem_to_reg  out  2  writeback: 00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  2  00 PC, 01 rs1 register A, 10 old PC
alu_src_b  out  2  00 register B, 01 constant 4, 10 imm_data
alu_op  out  2  00 add, 01 subtract (branch), 10 funct-decoded
state  out  4  current state encoding
retired  out  CNT_W  retired-instruction count
halted  out  1  1 in HALT

Behaviour:
- Encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, HALT 11.
- Reset low, asynchronous: state = FETCH, retired = 0. While reset is low, force pc_en, ir_write, reg_write, mem_read, and mem_write to 0. Force all selects to 0.
- Reset low mid-instruction aborts the instruction immediately. No partial write is counted. Release resumes at FETCH on the next edge.
- Moore outputs decode from state. pc_en, ir_write, and the branch decision are additionally qualified by mem_ready or zero, as stated below. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, A=00, B=01, alu_op=00, pc_src=0.
  - If mem_ready=1: ir_write=1, pc_en=1, next state DECODE.
  - Else: stay in FETCH with no enables.
- DECODE: A=10, B=10, alu_op=00 (target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → HALT
- EXEC_R: A=01, B=00, alu_op=10, next ALU_WB.
- EXEC_I: A=01, B=10, alu_op=10, next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, next FETCH (retire).
- MEM_ADDR: A=01, B=10, alu_op=00.
  - Next MEM_RD if latched opcode is 0000011.
  - Next MEM_WR if latched opcode is 0100011.
- MEM_RD: mem_read=1, iord=1. Wait while mem_ready=0. On mem_ready=1, next MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, next FETCH (retire).
- MEM_WR: mem_write=1, iord=1. Wait while mem_ready=0. On mem_ready=1, next FETCH (retire). mem_write stays high for every wait cycle.
- BRANCH: A=01, B=00, alu_op=01, pc_src=1, pc_en=zero, next FETCH (retire) whether or not the branch is taken.
- JAL: reg_write=1, mem_to_reg=10, pc_src=1, pc_en=1, next FETCH (retire).
  - Link and target use the same edge. The register file captures the PC value (already PC+4). The PC captures ALUOut.
- HALT: halted=1. Absorbing; only reset exits. retired is frozen.
- retired increments by 1 on each retiring transition into FETCH. It saturates at 2^CNT_W−1 with no wrap.
- Latencies (cycles, zero wait states): R/I = 4, ld = 5, sd = 4, beq = 3, jal = 3. Each memory wait cycle adds 1.
- opcode must remain stable from DECODE until the instruction retires. The FSM relies on it in MEM_ADDR.

Test Plan:
- Reset and R-type: hold reset=0 for 2 cycles; verify all strobes 0, state=0, retired=0. Release with mem_ready=1 and opcode=0110011; verify state sequence 0,1,6,8,0, reg_write=1 only in state 8, and retired=1.
- Load with wait states: opcode=0000011, mem_ready low for 3 cycles in MEM_RD. Verify the sequence 0,1,2,3,3,3,3,4,0, mem_read and iord=1 held in state 3, mem_to_reg=01 in state 4, and retired +1.
- Branch: opcode=1100011 with zero=1 gives pc_en=1 and pc_src=1 in state 9. Repeat with zero=0 and verify pc_en=0. Both cases retire after 3 cycles.
- JAL: opcode=1101111; verify that in state 10 reg_write=1, mem_to_reg=10, pc_en=1, and pc_src=1 are all asserted together.
- Illegal opcode and reset escape: opcode=0000000 leads to HALT (state 11, halted=1), and retired stays constant for 10 cycles. Then apply reset=0 asynchronously between clock edges; verify state=0 and halted=0 immediately, without waiting for a clock edge.
- Counter saturation: set CNT_W=3 and run 9 R-type instructions; verify retired steps 1..7 and then holds at 7.
